// File: rtl/bus_master_8086.sv
// Minimum-mode 8086 bus-cycle initiator: one client request becomes one T1..T4 bus cycle, stretched by READY wait states.
// Interrupt-acknowledge cycles (req_inta port, INTA strobe) are compiled in only when INTA_CYCLE_EN is defined.
module bus_master_8086 #(
  parameter int unsigned T_DIV    = 1,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        req,
  input  logic        req_wr,
  input  logic        req_mio,
  input  logic [19:0] req_addr,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
`ifdef INTA_CYCLE_EN
  input  logic        req_inta,
`endif
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic        INTA,
  output logic        DEN,
  output logic        DT_R,
  output logic        M_IO,
  output logic        BHE_S7,
  output logic [19:0] lad_out,
  output logic        lad_oe,
  input  logic [15:0] lad_in,
  input  logic        READY
);

  localparam int unsigned PW = (T_DIV > 1) ? $clog2(T_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

  typedef struct packed {
    logic        wr;
    logic        mio;
    logic        inta;
    logic [19:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } rq_t;

  typedef struct packed {
    logic        ale, rd, wr, inta, den, dt_r, m_io, bhe;
    logic        oe;
    logic [19:0] lad;
  } bus_t;

  localparam bus_t BUS_IDLE = '{ale: 1'b0, rd: 1'b1, wr: 1'b1, inta: 1'b1, den: 1'b1,
                                dt_r: 1'b0, m_io: 1'b0, bhe: 1'b1, oe: 1'b0, lad: 20'h0};

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    wcnt_q, wcnt_d;
  rq_t           rq_q, rq_d;
  logic          to_q, to_d;
  bus_t          bus_q, bus_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          last;
  logic          req_inta_w;

`ifdef INTA_CYCLE_EN
  assign req_inta_w = req_inta;
`else
  assign req_inta_w = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    wcnt_d  = wcnt_q;
    rq_d    = rq_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    last    = (pre_q == PW'(T_DIV - 1));

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (req_be == 2'b00 && !req_inta_w) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = S_T1;
            wcnt_d  = '0;
            to_d    = 1'b0;
            // An interrupt acknowledge is always a read of the I/O space.
            rq_d    = '{wr: req_wr & ~req_inta_w, mio: req_mio & ~req_inta_w, inta: req_inta_w,
                        addr: req_addr, be: req_be, wdata: req_wdata};
          end
        end
      end
      S_T1: if (last) state_d = S_T2;
      S_T2: if (last) state_d = S_T3;
      S_T3, S_TW: begin
        if (last) begin
          if (READY) begin
            state_d = S_T4;
            if (rq_q.inta)     rdata_d = {8'h00, lad_in[7:0]};
            else if (!rq_q.wr) rdata_d = lad_in;
          end else if (wcnt_q == 8'(WAIT_MAX)) begin
            state_d = S_T4;
            to_d    = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_TW;
            wcnt_d  = wcnt_q + 8'd1;
          end
        end
      end
      S_T4: if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && !last) pre_d = pre_q + PW'(1);

    // Outputs are registered, so they are derived from the state being entered.
    busy_d = (state_d != S_IDLE);
    if (state_d == S_T4 && pre_d == PW'(T_DIV - 1)) begin
      done_d = 1'b1;
      err_d  = to_d;
    end

    bus_d = BUS_IDLE;
    if (state_d != S_IDLE) begin
      bus_d.dt_r = rq_d.wr;
      bus_d.m_io = rq_d.mio;
      bus_d.bhe  = rq_d.inta | ~rq_d.be[1];
      bus_d.lad  = {rq_d.addr[19:1], ~rq_d.be[0]};
    end
    case (state_d)
      S_T1: begin
        bus_d.ale = 1'b1;
        bus_d.oe  = ~rq_d.inta;
      end
      S_T2, S_T3, S_TW: begin
        bus_d.den = 1'b0;
        if (rq_d.wr) begin
          bus_d.wr        = 1'b0;
          bus_d.oe        = 1'b1;
          bus_d.lad[15:0] = rq_d.wdata;
        end else if (rq_d.inta) begin
          bus_d.inta = 1'b0;
        end else begin
          bus_d.rd = 1'b0;
        end
      end
      S_T4: if (rq_d.wr) bus_d.lad[15:0] = rq_d.wdata;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      wcnt_q  <= '0;
      rq_q    <= '0;
      to_q    <= 1'b0;
      bus_q   <= BUS_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      wcnt_q  <= wcnt_d;
      rq_q    <= rq_d;
      to_q    <= to_d;
      bus_q   <= bus_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign ALE     = bus_q.ale;
  assign RD      = bus_q.rd;
  assign WR      = bus_q.wr;
  assign INTA    = bus_q.inta;
  assign DEN     = bus_q.den;
  assign DT_R    = bus_q.dt_r;
  assign M_IO    = bus_q.m_io;
  assign BHE_S7  = bus_q.bhe;
  assign lad_out = bus_q.lad;
  assign lad_oe  = bus_q.oe;

endmodule

// File: tb/tb_bus_master_8086.sv
// Bench for bus_master_8086: instance A (T_DIV=1, WAIT_MAX=4) and instance B (T_DIV=2, WAIT_MAX=255),
// checked clk by clk against a T-state timeline model. Interrupt-acknowledge checks run when INTA_CYCLE_EN is defined.
module tb_bus_master_8086;

  typedef struct packed {
    logic        rst, req, wr, mio, inta;
    logic [19:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata, lad_in;
    logic        ready;
  } in_t;

  typedef struct packed {
    logic        busy, done, err, ale, rd, wr, inta, den, dt_r, m_io, bhe, oe;
    logic [19:0] lad;
    logic [15:0] rdata;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  in_a = '0, in_b = '0;
  out_t mon_a, mon_b;
  logic busy_a, done_a, err_a, ale_a, rd_a, wr_a, inta_a, den_a, dtr_a, mio_a, bhe_a, oe_a;
  logic busy_b, done_b, err_b, ale_b, rd_b, wr_b, inta_b, den_b, dtr_b, mio_b, bhe_b, oe_b;
  logic [19:0] lad_a, lad_b;
  logic [15:0] rdata_a, rdata_b;

  assign mon_a = {busy_a, done_a, err_a, ale_a, rd_a, wr_a, inta_a, den_a, dtr_a, mio_a, bhe_a, oe_a, lad_a, rdata_a};
  assign mon_b = {busy_b, done_b, err_b, ale_b, rd_b, wr_b, inta_b, den_b, dtr_b, mio_b, bhe_b, oe_b, lad_b, rdata_b};

  bus_master_8086 #(.T_DIV(1), .WAIT_MAX(4)) dut_a (
    .clk(clk), .RESET(in_a.rst), .req(in_a.req), .req_wr(in_a.wr), .req_mio(in_a.mio),
    .req_addr(in_a.addr), .req_be(in_a.be), .req_wdata(in_a.wdata),
`ifdef INTA_CYCLE_EN
    .req_inta(in_a.inta),
`endif
    .busy(busy_a), .done(done_a), .err(err_a), .rdata(rdata_a), .ALE(ale_a), .RD(rd_a), .WR(wr_a),
    .INTA(inta_a), .DEN(den_a), .DT_R(dtr_a), .M_IO(mio_a), .BHE_S7(bhe_a), .lad_out(lad_a),
    .lad_oe(oe_a), .lad_in(in_a.lad_in), .READY(in_a.ready)
  );

  bus_master_8086 #(.T_DIV(2), .WAIT_MAX(255)) dut_b (
    .clk(clk), .RESET(in_b.rst), .req(in_b.req), .req_wr(in_b.wr), .req_mio(in_b.mio),
    .req_addr(in_b.addr), .req_be(in_b.be), .req_wdata(in_b.wdata),
`ifdef INTA_CYCLE_EN
    .req_inta(in_b.inta),
`endif
    .busy(busy_b), .done(done_b), .err(err_b), .rdata(rdata_b), .ALE(ale_b), .RD(rd_b), .WR(wr_b),
    .INTA(inta_b), .DEN(den_b), .DT_R(dtr_b), .M_IO(mio_b), .BHE_S7(bhe_b), .lad_out(lad_b),
    .lad_oe(oe_b), .lad_in(in_b.lad_in), .READY(in_b.ready)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_rd [2] = '{16'h0, 16'h0};

  task automatic check(input string tag, input out_t obs, input out_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic out_t idle_exp(input logic [15:0] rd);
    out_t e;
    e = '0;
    e.rd = 1'b1; e.wr = 1'b1; e.inta = 1'b1; e.den = 1'b1; e.bhe = 1'b1;
    e.rdata = rd;
    return e;
  endfunction

  function automatic out_t mon(input bit sel);
    return sel ? mon_b : mon_a;
  endfunction

  function automatic in_t cur_in(input bit sel);
    return sel ? in_b : in_a;
  endfunction

  task automatic drive(input bit sel, input in_t v);
    if (sel) in_b = v; else in_a = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer; nlow = READY-low samples before the first high one (beyond WAIT_MAX means timeout).
  task automatic run_xfer(input bit sel, input bit wr, input bit mio, input bit inta,
                          input logic [19:0] addr, input logic [1:0] be, input logic [15:0] wdata,
                          input int nlow, input bit hold, input int li_fix, input string tag);
    int td, wm, n, tot, s;
    bit tmo, act, wrx;
    logic [15:0] old_rd, new_rd, li;
    in_t v;
    out_t e, o;
    td = sel ? 2 : 1;
    wm = sel ? 255 : 4;
    tmo = (nlow > wm);
    n = tmo ? wm : nlow;
    tot = (4 + n) * td;
    wrx = wr && !inta;
    old_rd = exp_rd[sel];
    new_rd = old_rd;
    v = cur_in(sel);
    v.req = 1'b1; v.wr = wr; v.mio = mio; v.inta = inta; v.addr = addr; v.be = be; v.wdata = wdata;
    drive(sel, v);
    step();
    if (!hold) v.req = 1'b0;
    for (int k = 1; k <= tot; k++) begin
      s = (k - 1) / td;
      act = (s >= 1 && s <= 2 + n);
      e = '0;
      e.busy  = 1'b1;
      e.done  = (k == tot);
      e.err   = (k == tot) && tmo;
      e.ale   = (s == 0);
      e.rd    = !(act && !inta && !wr);
      e.wr    = !(act && wrx);
      e.inta  = !(act && inta);
      e.den   = !act;
      e.dt_r  = wrx;
      e.m_io  = mio && !inta;
      e.bhe   = inta ? 1'b1 : !be[1];
      e.oe    = (s == 0) ? !inta : (act && wrx);
      e.lad   = (s >= 1 && wrx) ? {addr[19:16], wdata} : {addr[19:1], !be[0]};
      e.rdata = (s >= 3 + n) ? new_rd : old_rd;
      o = mon(sel);
      if (!e.oe) begin
        o.lad[15:0] = '0;
        e.lad[15:0] = '0;
      end
      check($sformatf("%s clk%0d", tag, k), o, e);
      li = (li_fix >= 0) ? 16'(li_fix) : 16'($urandom);
      v.lad_in = li;
      if (s >= 2 && s <= 2 + n && k == (s + 1) * td) v.ready = !((s - 2) < nlow);
      else v.ready = 1'($urandom);
      if (k == (3 + n) * td) begin
        if (tmo)       new_rd = 16'h0;
        else if (inta) new_rd = {8'h00, li[7:0]};
        else if (!wr)  new_rd = li;
      end
      drive(sel, v);
      step();
    end
    exp_rd[sel] = new_rd;
    check({tag, " idle"}, mon(sel), idle_exp(new_rd));
  endtask

  initial begin
    in_t v;
    out_t e;
    in_a.rst = 1'b1;
    in_b.rst = 1'b1;
    step();
    step();
    check("reset A", mon_a, idle_exp(16'h0));
    check("reset B", mon_b, idle_exp(16'h0));
    in_a.rst = 1'b0;
    in_b.rst = 1'b0;
    step();

    run_xfer(0, 1'b0, 1'b1, 1'b0, 20'h12344, 2'b11, 16'h0000, 0, 1'b0, 16'hBEEF, "mem read");
    run_xfer(0, 1'b1, 1'b0, 1'b0, 20'h00031, 2'b01, 16'h00A5, 0, 1'b0, -1, "io write");
    run_xfer(1, 1'b0, 1'b1, 1'b0, 20'hA5A50, 2'b10, 16'h0000, 3, 1'b0, -1, "wait3 tdiv2");
    run_xfer(0, 1'b0, 1'b1, 1'b0, 20'h0F00E, 2'b11, 16'h0000, 9, 1'b0, -1, "timeout read");
    run_xfer(0, 1'b1, 1'b1, 1'b0, 20'h30002, 2'b11, 16'h1234, 9, 1'b0, -1, "timeout write");

    // Rejected request: single done+err pulse, no bus activity.
    v = in_a;
    v.req = 1'b1; v.be = 2'b00; v.inta = 1'b0;
    drive(0, v);
    step();
    e = idle_exp(exp_rd[0]);
    e.done = 1'b1;
    e.err  = 1'b1;
    check("reject pulse", mon_a, e);
    v.req = 1'b0;
    drive(0, v);
    step();
    check("reject after", mon_a, idle_exp(exp_rd[0]));

    // RESET in TW: reset values on the next clk, no done afterwards, then a normal transfer.
    v = in_a;
    v.req = 1'b1; v.wr = 1'b0; v.mio = 1'b1; v.inta = 1'b0; v.be = 2'b11; v.addr = 20'h55554; v.ready = 1'b0;
    drive(0, v);
    step();
    v.req = 1'b0;
    drive(0, v);
    step();
    step();
    step();
    e = mon_a;
    check("pre-reset in TW", {e.busy, e.rd, e.done}, 3'b100);
    v.rst = 1'b1;
    drive(0, v);
    step();
    exp_rd[0] = 16'h0;
    check("reset in TW", mon_a, idle_exp(16'h0));
    v.rst = 1'b0;
    drive(0, v);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("post-reset idle %0d", i), mon_a, idle_exp(16'h0));
    end
    run_xfer(0, 1'b0, 1'b0, 1'b0, 20'h003F8, 2'b01, 16'h0000, 1, 1'b0, -1, "after reset");

    // req held high: one IDLE clk between back-to-back transfers.
    run_xfer(1, 1'b1, 1'b1, 1'b0, 20'h00100, 2'b11, 16'hCAFE, 0, 1'b1, -1, "b2b first");
    run_xfer(1, 1'b0, 1'b1, 1'b0, 20'h00100, 2'b11, 16'hCAFE, 1, 1'b0, -1, "b2b second");

`ifdef INTA_CYCLE_EN
    run_xfer(0, 1'b1, 1'b1, 1'b1, 20'hFFFFF, 2'b00, 16'hFFFF, 0, 1'b0, 16'h1208, "inta");
    run_xfer(1, 1'b0, 1'b1, 1'b1, 20'h12345, 2'b11, 16'h0000, 2, 1'b0, -1, "inta wait");
`endif

    for (int i = 0; i < 30; i++) begin
      bit sel, inta;
      int nlow;
      sel = 1'($urandom);
      inta = 1'b0;
`ifdef INTA_CYCLE_EN
      inta = ($urandom_range(0, 5) == 0);
`endif
      nlow = $urandom_range(0, 3);
      if (!sel && $urandom_range(0, 4) == 0) nlow = 6;
      run_xfer(sel, 1'($urandom), 1'($urandom), inta, 20'($urandom), 2'($urandom_range(1, 3)),
               16'($urandom), nlow, 1'b0, -1, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
